// File: rtl/bram_logger_readout_ctrl_pkg.sv
// Shared types, widths and helpers for the BRAM logger read-out controller.
package bram_log_ctrl_pkg;

    localparam int unsigned BYTES_PER_WORD      = 4;
    localparam int unsigned DATA_BITW           = 32;
    localparam int unsigned DEF_NUM_LOG_ENTRIES = 16384;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLEAR_WAIT,
        ST_ARMED,
        ST_DRAIN
    } ctrl_state_e;

    // One word returned by the BRAM port, tagged with its end-of-drain flag.
    typedef struct packed {
        logic                 last;
        logic [DATA_BITW-1:0] data;
    } rd_word_t;

    // Entry counter width: must hold the value NUM_LOG_ENTRIES itself.
    function automatic int unsigned cnt_bitw(input int unsigned num_entries);
        return 32'($clog2(num_entries)) + 32'd1;
    endfunction

    // Word index width: must hold the total word count without wrapping.
    function automatic int unsigned idx_bitw(input int unsigned num_entries,
                                             input int unsigned words_per_entry);
        return 32'($clog2(num_entries * words_per_entry)) + 32'd1;
    endfunction

    localparam int unsigned CNT_BITW = cnt_bitw(DEF_NUM_LOG_ENTRIES);

endpackage

// File: rtl/bram_logger_readout_ctrl_rd_skid.sv
// Two-entry FIFO holding BRAM read returns until the stream consumer takes them.
module bram_rd_skid
    import bram_log_ctrl_pkg::*;
(
    input  logic        Clk_CI,
    input  logic        Rst_RBI,
    input  logic        Push_SI,
    input  rd_word_t    PushWord_DI,
    input  logic        Pop_SI,
    output logic        HeadValid_SO,
    output rd_word_t    HeadWord_DO,
    output logic [1:0]  Occupancy_DO
);

    rd_word_t   mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;

    // Storage, pointers and occupancy; the read issue logic guarantees no push when full.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (Push_SI) begin
                mem_q[wr_ptr_q] <= PushWord_DI;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (Pop_SI) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + 2'(Push_SI) - 2'(Pop_SI);
        end
    end

    // Head word is zeroed while empty so the stream shows no stale data.
    assign HeadValid_SO = (occ_q != 2'd0);
    assign HeadWord_DO  = HeadValid_SO ? mem_q[rd_ptr_q] : '0;
    assign Occupancy_DO = occ_q;

endmodule

// File: rtl/bram_logger_readout_ctrl.sv
// Sequences a BRAM logger through clear/arm/capture/stop and streams the captured words out.
module bram_logger_readout_ctrl
    import bram_log_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LOG_ENTRIES = 16384,
    parameter int unsigned WORDS_PER_ENTRY = 2,
    parameter int unsigned ADDR_BITW       = 32
) (
    input  logic                                 Clk_CI,
    input  logic                                 Rst_RBI,
    input  logic                                 Arm_SI,
    input  logic                                 Stop_SI,
    input  logic                                 Drain_SI,
    input  logic                                 EvtTrigger_SI,
    output logic                                 LogTrigger_SO,
    output logic                                 LogEn_SO,
    output logic                                 Clear_SO,
    input  logic                                 LoggerReady_SI,
    input  logic                                 LoggerFull_SI,
    output logic                                 BramEn_SO,
    output logic [ADDR_BITW-1:0]                 BramAddr_SO,
    input  logic [31:0]                          BramRdData_DI,
    output logic [31:0]                          StrData_DO,
    output logic                                 StrValid_SO,
    input  logic                                 StrReady_SI,
    output logic                                 StrLast_SO,
    output logic [cnt_bitw(NUM_LOG_ENTRIES)-1:0] NumEntries_DO,
    output logic                                 Busy_SO
);

    localparam int unsigned      CNT_W   = cnt_bitw(NUM_LOG_ENTRIES);
    localparam int unsigned      IDX_W   = idx_bitw(NUM_LOG_ENTRIES, WORDS_PER_ENTRY);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_LOG_ENTRIES);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [IDX_W-1:0] total_words;
    logic             rd_pend_q;
    logic             rd_pend_last_q;
    logic             at_last_rd;
    logic             cnt_full;
    logic             str_pop;
    logic [1:0]       skid_occ;
    logic [2:0]       rd_credit;
    rd_word_t         push_word;
    rd_word_t         head_word;
    logic             full_unused;

    // Full status is informational only; the entry count already bounds capture.
    assign full_unused = LoggerFull_SI;

    assign total_words   = IDX_W'(count_q) * IDX_W'(WORDS_PER_ENTRY);
    assign at_last_rd    = (rd_idx_q == total_words - IDX_W'(1));
    assign cnt_full      = (count_q == CNT_MAX);
    assign str_pop       = StrValid_SO & StrReady_SI;
    // Words already buffered or in flight, crediting a pop happening this cycle.
    assign rd_credit     = 3'(skid_occ) + 3'(rd_pend_q) - 3'(str_pop);
    assign BramAddr_SO   = ADDR_BITW'(rd_idx_q) * ADDR_BITW'(BYTES_PER_WORD);
    assign NumEntries_DO = count_q;
    assign push_word     = '{last: rd_pend_last_q, data: BramRdData_DI};
    assign StrData_DO    = head_word.data;
    assign StrLast_SO    = head_word.last;

    // State register.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d       = state_q;
        Clear_SO      = 1'b0;
        LogEn_SO      = 1'b0;
        LogTrigger_SO = 1'b0;
        BramEn_SO     = 1'b0;
        Busy_SO       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                Busy_SO = 1'b0;
                if (Arm_SI) begin
                    state_d = ST_CLEAR;
                end else if (Drain_SI && (count_q != '0)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                Clear_SO = 1'b1;
                state_d  = ST_CLEAR_WAIT;
            end
            ST_CLEAR_WAIT: begin
                if (LoggerReady_SI) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                LogEn_SO      = 1'b1;
                LogTrigger_SO = EvtTrigger_SI & LoggerReady_SI & ~cnt_full & ~Stop_SI;
                if (Stop_SI || cnt_full) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                BramEn_SO = (rd_idx_q != total_words) && (rd_credit < 3'd2);
                if (str_pop && StrLast_SO) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Entry counter, read index and the one-deep read-in-flight tracker.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            count_q        <= '0;
            rd_idx_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR) begin
                count_q <= '0;
            end else if (LogTrigger_SO) begin
                count_q <= count_q + CNT_W'(1);
            end
            rd_pend_q      <= BramEn_SO;
            rd_pend_last_q <= BramEn_SO & at_last_rd;
            if ((state_q != ST_DRAIN) || (state_d != ST_DRAIN)) begin
                rd_idx_q <= '0;
            end else if (BramEn_SO) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
        end
    end

    bram_rd_skid i_skid (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .Push_SI      (rd_pend_q),
        .PushWord_DI  (push_word),
        .Pop_SI       (str_pop),
        .HeadValid_SO (StrValid_SO),
        .HeadWord_DO  (head_word),
        .Occupancy_DO (skid_occ)
    );

endmodule

// File: tb/tb_bram_logger_readout_ctrl.sv
// Bench for bram_logger_readout_ctrl: per-cycle behavioural model plus directed scenarios.
module tb_bram_logger_readout_ctrl;

    localparam int N_ENT = 1024;
    localparam int WPE   = 2;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_CWAIT = 2, P_ARMED = 3, P_DRAIN = 4;
    localparam logic [3:0] RDY_PAT = 4'b1001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, stop, drain, evt, log_ready, log_full, str_ready;
    logic [31:0] bram_rdata;
    logic        log_trig, log_en, clear, bram_en, str_valid, str_last, busy;
    logic [31:0] bram_addr, str_data;
    logic [10:0] num_entries;

    int checks = 0;
    int errors = 0;

    // Model state and statistics, written only by the compare process.
    int m_phase = P_IDLE, m_cnt = 0, m_words = 0, m_iss = 0, m_k = 0, cyc = 0;
    int n_hs = 0, n_last = 0, n_trig = 0, n_iss = 0, armed_cyc = 0;
    int drain_start = 0, first_valid = -1, drain_len = 0;
    logic [31:0] last_rd_addr = '0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    logic        c_trig, c_hs;

    bram_logger_readout_ctrl #(
        .NUM_LOG_ENTRIES (N_ENT),
        .WORDS_PER_ENTRY (WPE),
        .ADDR_BITW       (32)
    ) dut (
        .Clk_CI         (clk),
        .Rst_RBI        (rst_n),
        .Arm_SI         (arm),
        .Stop_SI        (stop),
        .Drain_SI       (drain),
        .EvtTrigger_SI  (evt),
        .LogTrigger_SO  (log_trig),
        .LogEn_SO       (log_en),
        .Clear_SO       (clear),
        .LoggerReady_SI (log_ready),
        .LoggerFull_SI  (log_full),
        .BramEn_SO      (bram_en),
        .BramAddr_SO    (bram_addr),
        .BramRdData_DI  (bram_rdata),
        .StrData_DO     (str_data),
        .StrValid_SO    (str_valid),
        .StrReady_SI    (str_ready),
        .StrLast_SO     (str_last),
        .NumEntries_DO  (num_entries),
        .Busy_SO        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        return 32'h5A00_0000 ^ {a[15:0], ~a[15:0]};
    endfunction

    // BRAM: data for the address presented with the enable appears one cycle later.
    always @(posedge clk) begin
        if (bram_en) bram_rdata <= bram_word(bram_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    // Compare process: checks every output against the model mid-cycle, then advances the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctrl", 64'({log_trig, log_en, clear, bram_en, str_valid, str_last, busy, num_entries}), 64'd0);
            chk("rst_data", {bram_addr, str_data}, 64'd0);
            m_phase    = P_IDLE;
            m_cnt      = 0;
            m_iss      = 0;
            m_k        = 0;
            prev_stall = 1'b0;
        end else begin
            c_trig = (m_phase == P_ARMED) && evt && log_ready && (m_cnt < N_ENT) && !stop;
            c_hs   = str_valid && str_ready;
            chk("busy",    64'(busy),        64'(m_phase != P_IDLE));
            chk("clear",   64'(clear),       64'(m_phase == P_CLEAR));
            chk("log_en",  64'(log_en),      64'(m_phase == P_ARMED));
            chk("log_trig",64'(log_trig),    64'(c_trig));
            chk("entries", 64'(num_entries), 64'(m_cnt));
            if (prev_stall) chk("stall_hold", 64'({str_valid, str_last, str_data}), 64'(prev_word));
            prev_stall = str_valid && !str_ready;
            prev_word  = {str_valid, str_last, str_data};
            case (m_phase)
                P_IDLE: begin
                    chk("valid_outside_drain", 64'(str_valid), 64'd0);
                    chk("bram_en_outside_drain", 64'(bram_en), 64'd0);
                    if (arm) begin
                        m_phase = P_CLEAR;
                    end else if (drain && m_cnt > 0) begin
                        m_phase     = P_DRAIN;
                        m_words     = m_cnt * WPE;
                        m_iss       = 0;
                        m_k         = 0;
                        drain_start = cyc + 1;
                        first_valid = -1;
                    end
                end
                P_CLEAR: begin
                    m_cnt   = 0;
                    m_phase = P_CWAIT;
                end
                P_CWAIT: begin
                    if (log_ready) m_phase = P_ARMED;
                end
                P_ARMED: begin
                    armed_cyc++;
                    if (stop || m_cnt == N_ENT) m_phase = P_IDLE;
                    if (c_trig) begin
                        m_cnt++;
                        n_trig++;
                    end
                end
                P_DRAIN: begin
                    if (first_valid < 0 && str_valid) first_valid = cyc;
                    if (bram_en) begin
                        chk("bram_addr", 64'(bram_addr), 64'(m_iss * 4));
                        chk("bram_in_range", 64'(m_iss < m_words), 64'd1);
                        last_rd_addr = bram_addr;
                        n_iss++;
                        m_iss++;
                    end
                    if (c_hs) begin
                        chk("str_data", 64'(str_data), 64'(bram_word(32'(m_k * 4))));
                        chk("str_last", 64'(str_last), 64'(m_k == m_words - 1));
                        n_hs++;
                        if (str_last) n_last++;
                        m_k++;
                    end
                    chk("outstanding", 64'((m_iss - m_k) <= 2), 64'd1);
                    if (c_hs && m_k == m_words) begin
                        m_phase   = P_IDLE;
                        drain_len = cyc - drain_start + 1;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
        cyc++;
    end

    initial begin
        int hs0, last0, iss0, trig0, arm0, n;
        rst_n = 1'b0; arm = 1'b0; stop = 1'b0; drain = 1'b0; evt = 1'b0;
        log_ready = 1'b1; log_full = 1'b0; str_ready = 1'b1;
        repeat (2) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(bram_addr), 64'd0);
        rst_n = 1'b1;
        step();

        // Arm straight after reset: CLEAR on cycle 1, one wait cycle, ARMED on cycle 3.
        arm = 1'b1; step(); arm = 1'b0;
        chk("a_clear_pulse", 64'(clear), 64'd1);
        step();
        chk("a_clear_once", 64'(clear), 64'd0);
        chk("a_cwait_not_en", 64'(log_en), 64'd0);
        step();
        chk("a_armed_cycle3", 64'(log_en), 64'd1);
        log_ready = 1'b0; evt = 1'b1; #1;
        chk("a_trig_needs_ready", 64'(log_trig), 64'd0);
        step(); evt = 1'b0; log_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            evt = 1'b1; #1;
            chk("a_trig_pass", 64'(log_trig), 64'd1);
            step(); evt = 1'b0; step();
        end
        chk("a_five_entries", 64'(num_entries), 64'd5);
        stop = 1'b1; step(); stop = 1'b0;
        chk("a_stop_idle", 64'(busy), 64'd0);

        // Drain 10 words with ready held high.
        hs0 = n_hs; last0 = n_last; iss0 = n_iss;
        drain = 1'b1; step(); drain = 1'b0;
        wait_idle(100, "a_drain_timeout");
        chk("a_words", 64'(n_hs - hs0), 64'd10);
        chk("a_reads", 64'(n_iss - iss0), 64'd10);
        chk("a_last_count", 64'(n_last - last0), 64'd1);
        chk("a_last_addr", 64'(last_rd_addr), 64'h24);
        chk("a_first_valid_lat", 64'(first_valid - drain_start), 64'd2);
        chk("a_drain_len", 64'(drain_len), 64'd12);
        chk("a_count_kept", 64'(num_entries), 64'd5);

        // Re-drain with ready toggling 1,0,0,1.
        hs0 = n_hs; last0 = n_last;
        drain = 1'b1; step(); drain = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            str_ready = RDY_PAT[n % 4];
            step();
            n++;
        end
        str_ready = 1'b1;
        chk("b_drain_done", 64'(busy), 64'd0);
        chk("b_words", 64'(n_hs - hs0), 64'd10);
        chk("b_last_count", 64'(n_last - last0), 64'd1);

        // Arm wins over Drain; CLEAR_WAIT holds while the logger is not ready.
        arm = 1'b1; drain = 1'b1; step(); arm = 1'b0; drain = 1'b0; log_ready = 1'b0;
        chk("c_arm_wins", 64'(clear), 64'd1);
        repeat (3) step();
        chk("c_cwait_hold", 64'({busy, log_en}), 64'b10);
        log_ready = 1'b1; step();
        chk("c_armed", 64'(log_en), 64'd1);
        stop = 1'b1; evt = 1'b1; #1;
        chk("c_stop_blocks_trig", 64'(log_trig), 64'd0);
        step(); stop = 1'b0; evt = 1'b0;
        chk("c_stop_idle", 64'(busy), 64'd0);
        chk("c_count_zero", 64'(num_entries), 64'd0);

        // Continuous trigger saturates at capacity and ends the session.
        arm = 1'b1; step(); arm = 1'b0; step(); step();
        trig0 = n_trig; arm0 = armed_cyc;
        evt = 1'b1; log_full = 1'b1;
        wait_idle(1200, "d_sat_timeout");
        evt = 1'b0; log_full = 1'b0;
        chk("d_triggers", 64'(n_trig - trig0), 64'd1024);
        chk("d_armed_cycles", 64'(armed_cyc - arm0), 64'd1025);
        chk("d_saturated", 64'(num_entries), 64'd1024);

        // Reset in the middle of a drain, at word 3.
        hs0 = n_hs;
        drain = 1'b1; step(); drain = 1'b0;
        n = 0;
        while ((n_hs - hs0) < 3 && n < 50) begin
            step();
            n++;
        end
        chk("e_reached_word3", 64'(n_hs - hs0), 64'd3);
        chk("e_streaming", 64'(str_valid), 64'd1);
        rst_n = 1'b0; #1;
        chk("e_async_ctrl", 64'({str_valid, str_last, bram_en, busy, num_entries}), 64'd0);
        chk("e_async_data", {bram_addr, str_data}, 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        drain = 1'b1; step(); drain = 1'b0; step();
        chk("e_drain_ignored", 64'({busy, str_valid}), 64'd0);
        chk("e_count_zero", 64'(num_entries), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
